data_mem_req: RTL and testbench
===============================

DATA_MEM_REQ -- requirements
Module: data_mem_req

Interface
REQ-001 The module SHALL have parameter DEPTH, default 256, meaning the number of 64-bit words (power of two, 16..4096).
REQ-002 The module SHALL have parameter ADDR_W, default 64, meaning the byte-address width.
REQ-003 The module SHALL have parameter LAT, default 1, meaning request-to-response latency in cycles (legal 1..4).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for double and for stores.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  64  store data, right-aligned (valid bytes in the low lanes).
REQ-013 resp_valid  out  1  response present.
REQ-014 resp_ready  in  1  consumer accepts response.
REQ-015 resp_rdata  out  64  load result, extended to 64 bits; 0 for stores and errors.
REQ-016 resp_err  out  1  request was misaligned or out of range.

Function
REQ-017 Word index SHALL be req_addr[log2(DEPTH)+2:3]; byte lane SHALL be req_addr[2:0].
REQ-018 Misaligned: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0; out of range: any req_addr bit above log2(DEPTH)+2 set; either SHALL raise resp_err.
REQ-019 FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; at most one request outstanding.
REQ-020 Handshake: acceptance occurs on a rising edge with req_valid & req_ready; IDLE->RESP when LAT=1, else IDLE->WAIT with the latency counter loaded with LAT-2.
REQ-021 WAIT SHALL decrement the counter each cycle and move to RESP when it reaches 0; resp_valid SHALL first be 1 exactly LAT cycles after the acceptance edge.
REQ-022 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until an edge with resp_ready=1, then return to IDLE (no same-cycle new acceptance).
REQ-023 A store SHALL write only the addressed byte lanes of the word (byte-enable) on the acceptance edge; an erroring store SHALL write nothing.
REQ-024 Load data SHALL be captured from the array on the acceptance edge, shifted right by 8*lane, then zero- or sign-extended from bit 7/15/31 per size.
REQ-025 A load accepted in the cycle after a store to the same word SHALL return the stored data.
REQ-026 req_valid with req_ready=0 SHALL have no effect; requesters hold the request.

Reset
REQ-027 During rst: state IDLE, counter 0, req_ready 0 while rst=1 then 1, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-028 Reset mid-operation SHALL abort the pending response; a store already accepted SHALL remain written.
REQ-029 Memory array contents SHALL NOT be reset and are undefined until written.

Structure
REQ-030 Package data_mem_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state enum.
REQ-031 Lane shift, extension and byte-enable generation SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-032 LAT=1: store double 0x1122334455667788 at 0x248, load double 0x248 -> resp_valid one cycle after acceptance, rdata 0x1122334455667788, err 0.
REQ-033 Store byte 0xFE at 0x249, signed load byte 0x249 -> 0xFFFFFFFFFFFFFFFE; unsigned -> 0x00000000000000FE; load double 0x248 -> 0x112233445566FE88.
REQ-034 Load half at 0x24B -> err 1, rdata 0; store word at 0x24A -> err 1, memory at 0x248 unchanged.
REQ-035 LAT=3, resp_ready held 0 for 5 cycles -> resp_valid rises 3 cycles after acceptance, data stable, req_ready 0 until the resp_ready edge.
REQ-036 rst asserted while in WAIT -> resp_valid 0 immediately, state IDLE, no response delivered after release.
REQ-037 DEPTH=256, address 0x800 -> err 1 (out of range).

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory request block: access sizes and FSM states.
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-enables and data placement, load shift and extension.
// Zero latency; no flow control of its own.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rword_i,
  output logic [7:0]  be_o,
  output logic [63:0] wword_o,
  output logic [63:0] rdata_o
);

  logic [63:0] sh;

  always_comb begin
    sh      = rword_i >> {lane_i, 3'b000};
    wword_o = wdata_i << {lane_i, 3'b000};
    be_o    = 8'hFF;
    rdata_o = sh;
    case (size_i)
      SZ_B: begin
        be_o    = 8'h01 << lane_i;
        rdata_o = unsigned_i ? {56'd0, sh[7:0]} : {{56{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        be_o    = 8'h03 << lane_i;
        rdata_o = unsigned_i ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      end
      SZ_W: begin
        be_o    = 8'h0F << lane_i;
        rdata_o = unsigned_i ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      end
      default: begin
        be_o    = 8'hFF;
        rdata_o = sh;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_req.sv
// Single-outstanding 64-bit data memory with sized, byte-lane loads/stores; response after LAT cycles.
// req_ready only in IDLE; the response is held until resp_ready is seen on a clock edge.
module data_mem_req
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 64,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             misal, oor, err, accept, wr_en;
  logic [7:0]       be;
  logic [63:0]      wword, ld_data;

  assign idx    = req_addr[IDX_W+2:3];
  assign oor    = |req_addr[ADDR_W-1:IDX_W+3];
  assign err    = misal | oor;
  assign accept = req_valid & req_ready;
  assign wr_en  = accept & req_we & ~err;

  always_comb begin
    misal = 1'b0;
    case (req_size)
      SZ_H:    misal = req_addr[0];
      SZ_W:    misal = |req_addr[1:0];
      SZ_D:    misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
  end

  mem_lane_align u_align (
    .size_i     (req_size),
    .unsigned_i (req_unsigned),
    .lane_i     (req_addr[2:0]),
    .wdata_i    (req_wdata),
    .rword_i    (mem[idx]),
    .be_o       (be),
    .wword_o    (wword),
    .rdata_o    (ld_data)
  );

  // Array is deliberately unreset: contents survive rst and start undefined.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (req_we | err) ? 64'd0 : ld_data;
          err_d   = err;
          if (LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 2'(LAT - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE) & ~rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_req.sv
// Directed bench for data_mem_req: LAT=1 instance (a) and LAT=3 instance (b), scoreboard-checked.
module tb_data_mem_req;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic        req_valid, req_we, req_unsigned, resp_ready;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;

  logic        req_ready_a, resp_valid_a, resp_err_a;
  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [63:0] resp_rdata_a, resp_rdata_b;

  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;

  assign req_ready  = sel ? req_ready_b  : req_ready_a;
  assign resp_valid = sel ? resp_valid_b : resp_valid_a;
  assign resp_err   = sel ? resp_err_b   : resp_err_a;
  assign resp_rdata = sel ? resp_rdata_b : resp_rdata_a;

  data_mem_req #(.DEPTH(256), .ADDR_W(64), .LAT(1)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(req_valid & ~sel), .req_ready(req_ready_a),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready & ~sel),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
  );

  data_mem_req #(.DEPTH(256), .ADDR_W(64), .LAT(3)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(req_valid & sel), .req_ready(req_ready_b),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready & sel),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [64:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "/ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic transact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rd, input logic exp_err,
                          input int hold, input int lat);
    int k;
    logic [64:0] e;
    wait_ready(tag);
    sb_q.push_back({exp_err, exp_rd});
    drive(we, sz, uns, addr, wdata);
    k = 0;
    while (resp_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "/lat"}, 64'(k + 1), 64'(lat));
    e = sb_q.pop_front();
    check({tag, "/rdata"}, resp_rdata, e[63:0]);
    check({tag, "/err"}, 64'(resp_err), 64'(e[64]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "/hold_rdata"}, resp_rdata, e[63:0]);
      check({tag, "/hold_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "/done_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "/done_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic abort_in_wait(input string tag, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata);
    wait_ready(tag);
    drive(we, SZ_D, 1'b0, addr, wdata);
    check({tag, "/wait_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "/wait_ready"}, 64'(req_ready), 64'd0);
    rst_b = 1'b1;
    #1;
    check({tag, "/rst_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "/rst_ready"}, 64'(req_ready), 64'd0);
    check({tag, "/rst_rdata"}, resp_rdata, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check({tag, "/post_valid"}, 64'(resp_valid), 64'd0);
    end
    check({tag, "/post_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_unsigned = 1'b0; resp_ready = 1'b0;
    req_size = SZ_D; req_addr = 64'd0; req_wdata = 64'd0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst/req_ready", 64'(req_ready), 64'd0);
      check("rst/resp_valid", 64'(resp_valid), 64'd0);
      check("rst/resp_rdata", resp_rdata, 64'd0);
      check("rst/resp_err", 64'(resp_err), 64'd0);
    end
    sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    check("rel/req_ready_a", 64'(req_ready), 64'd1);

    // LAT=1 instance
    transact("st_d",      1, SZ_D, 0, 64'h248, 64'h1122334455667788, 64'd0, 0, 0, 1);
    transact("ld_d",      0, SZ_D, 0, 64'h248, 64'd0, 64'h1122334455667788, 0, 0, 1);
    transact("st_b",      1, SZ_B, 0, 64'h249, 64'hAAAAAAAAAAAAAAFE, 64'd0, 0, 0, 1);
    transact("ld_b_s",    0, SZ_B, 0, 64'h249, 64'd0, 64'hFFFFFFFFFFFFFFFE, 0, 0, 1);
    transact("ld_b_u",    0, SZ_B, 1, 64'h249, 64'd0, 64'h00000000000000FE, 0, 0, 1);
    transact("ld_d2",     0, SZ_D, 0, 64'h248, 64'd0, 64'h112233445566FE88, 0, 0, 1);
    transact("ld_h_mis",  0, SZ_H, 0, 64'h24B, 64'd0, 64'd0, 1, 0, 1);
    transact("st_w_mis",  1, SZ_W, 0, 64'h24A, 64'hDEADBEEF, 64'd0, 1, 0, 1);
    transact("st_b_oor",  1, SZ_B, 0, 64'hA49, 64'h00, 64'd0, 1, 0, 1);
    transact("ld_d3",     0, SZ_D, 0, 64'h248, 64'd0, 64'h112233445566FE88, 0, 0, 1);
    transact("ld_d_oor",  0, SZ_D, 0, 64'h800, 64'd0, 64'd0, 1, 0, 1);
    transact("ld_d_mis",  0, SZ_D, 0, 64'h24C, 64'd0, 64'd0, 1, 0, 1);
    transact("st_h",      1, SZ_H, 0, 64'h24C, 64'h555555555555ABCD, 64'd0, 0, 0, 1);
    transact("ld_h_s",    0, SZ_H, 0, 64'h24C, 64'd0, 64'hFFFFFFFFFFFFABCD, 0, 0, 1);
    transact("ld_w_u",    0, SZ_W, 1, 64'h24C, 64'd0, 64'h000000001122ABCD, 0, 0, 1);
    transact("ld_w_s_lo", 0, SZ_W, 0, 64'h248, 64'd0, 64'h000000005566FE88, 0, 0, 1);
    transact("ld_h_u_hi", 0, SZ_H, 1, 64'h24E, 64'd0, 64'h0000000000001122, 0, 0, 1);
    transact("ld_b_s_hi", 0, SZ_B, 0, 64'h24F, 64'd0, 64'h0000000000000011, 0, 0, 1);
    transact("st_w",      1, SZ_W, 0, 64'h250, 64'h1234567889ABCDEF, 64'd0, 0, 0, 1);
    transact("ld_w_s",    0, SZ_W, 0, 64'h250, 64'd0, 64'hFFFFFFFF89ABCDEF, 0, 0, 1);
    transact("ld_w_u2",   0, SZ_W, 1, 64'h250, 64'd0, 64'h0000000089ABCDEF, 0, 2, 1);

    // LAT=3 instance
    sel = 1'b1;
    #1;
    transact("b_st_d",    1, SZ_D, 0, 64'h10, 64'h0123456789ABCDEF, 64'd0, 0, 0, 3);
    transact("b_ld_hold", 0, SZ_D, 0, 64'h10, 64'd0, 64'h0123456789ABCDEF, 0, 5, 3);
    abort_in_wait("b_abort_ld", 1'b0, 64'h10, 64'd0);
    abort_in_wait("b_abort_st", 1'b1, 64'h20, 64'hCAFEF00D12345678);
    transact("b_ld_kept", 0, SZ_D, 0, 64'h20, 64'd0, 64'hCAFEF00D12345678, 0, 0, 3);
    transact("b_ld_oor",  0, SZ_B, 1, 64'h800, 64'd0, 64'd0, 1, 1, 3);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
